// File: rtl/my_control_unit.sv
// rtl/my_control_unit.sv - instruction sequencer decoding mv/mvi/add/sub into datapath enables
module my_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [8:0] instr,
    output logic [9:0] reg_enable_out,
    output logic [9:0] reg_enable_in,
    output logic       addsub,
    output logic       done,
    output logic       busy,
    output logic       illegal
);
    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    state_t     state;
    state_t     state_nxt;
    logic [8:0] ir;
    logic [2:0] opc;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       is_arith;

    assign opc      = ir[8:6];
    assign rx       = ir[5:3];
    assign ry       = ir[2:0];
    assign is_arith = (opc == OP_ADD) || (opc == OP_SUB);

    function automatic logic [9:0] sel(input logic [3:0] idx);
        sel = 10'b1 << idx;
    endfunction

    // IR is only written on the edge that leaves IDLE, so run/instr during busy are ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && run)
                ir <= instr;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = run ? T1 : IDLE;
            T1:      state_nxt = is_arith ? T2 : IDLE;
            T2:      state_nxt = T3;
            T3:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        reg_enable_out = '0;
        reg_enable_in  = '0;
        addsub         = 1'b0;
        done           = 1'b0;
        illegal        = 1'b0;
        busy           = (state != IDLE);
        case (state)
            T1: begin
                case (opc)
                    OP_MV: begin
                        reg_enable_out = sel({1'b0, ry});
                        reg_enable_in  = sel({1'b0, rx});
                        done           = 1'b1;
                    end
                    OP_MVI: begin
                        reg_enable_out = sel(4'd9);
                        reg_enable_in  = sel({1'b0, rx});
                        done           = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        reg_enable_out = sel({1'b0, rx});
                        reg_enable_in  = sel(4'd9);
                    end
                    default: begin
                        done    = 1'b1;
                        illegal = 1'b1;
                    end
                endcase
            end
            T2: begin
                reg_enable_out = sel({1'b0, ry});
                reg_enable_in  = sel(4'd8);
                addsub         = (opc == OP_SUB);
            end
            T3: begin
                reg_enable_out = sel(4'd8);
                reg_enable_in  = sel({1'b0, rx});
                done           = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_my_control_unit.sv
// tb/tb_my_control_unit.sv - self-checking bench for my_control_unit
module tb_my_control_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic [8:0] instr = '0;
    logic [9:0] reg_enable_out;
    logic [9:0] reg_enable_in;
    logic       addsub;
    logic       done;
    logic       busy;
    logic       illegal;

    int total = 0;
    int bad   = 0;

    my_control_unit dut (
        .clk(clk), .rst(rst), .run(run), .instr(instr),
        .reg_enable_out(reg_enable_out), .reg_enable_in(reg_enable_in),
        .addsub(addsub), .done(done), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] eo;
        logic [9:0] ei;
        logic       as;
        logic       dn;
        logic       il;
    } exp_t;

    exp_t model_q[$];

    function automatic logic [9:0] bit_of(input int n);
        logic [9:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // Expected per-cycle activity of one instruction, straight from the instruction table
    task automatic enqueue(input logic [8:0] w);
        int op;
        int x;
        int y;
        op = int'(w[8:6]);
        x  = int'(w[5:3]);
        y  = int'(w[2:0]);
        if (op == 0)
            model_q.push_back('{bit_of(y), bit_of(x), 1'b0, 1'b1, 1'b0});
        else if (op == 1)
            model_q.push_back('{bit_of(9), bit_of(x), 1'b0, 1'b1, 1'b0});
        else if (op == 2 || op == 3) begin
            model_q.push_back('{bit_of(x), bit_of(9), 1'b0, 1'b0, 1'b0});
            model_q.push_back('{bit_of(y), bit_of(8), (op == 3), 1'b0, 1'b0});
            model_q.push_back('{bit_of(8), bit_of(x), 1'b0, 1'b1, 1'b0});
        end else
            model_q.push_back('{10'd0, 10'd0, 1'b0, 1'b1, 1'b1});
    endtask

    always @(negedge rst) model_q.delete();

    always @(posedge clk) begin
        if (rst) begin
            if (model_q.size() == 0) begin
                if (run) enqueue(instr);
            end else
                void'(model_q.pop_front());
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            e = (model_q.size() == 0) ? '0 : model_q[0];
            check("m_out",  32'(reg_enable_out), 32'(e.eo));
            check("m_in",   32'(reg_enable_in),  32'(e.ei));
            check("m_as",   32'(addsub),  32'(e.as));
            check("m_done", 32'(done),    32'(e.dn));
            check("m_ill",  32'(illegal), 32'(e.il));
            check("m_busy", 32'(busy),    32'(model_q.size() != 0));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [8:0] w);
        run = 1'b1;
        instr = w;
        tick();
        run = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_out",  32'(reg_enable_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // mvi R5
        issue(9'b001_101_000);
        check("mvi_out",  32'(reg_enable_out), 32'h200);
        check("mvi_in",   32'(reg_enable_in),  32'h020);
        check("mvi_done", 32'(done), 32'h1);
        check("mvi_busy", 32'(busy), 32'h1);
        tick();
        check("mvi_idle", 32'(busy), 32'h0);

        // mv R1,R5
        issue(9'b000_001_101);
        check("mv_out", 32'(reg_enable_out), 32'h020);
        check("mv_in",  32'(reg_enable_in),  32'h002);
        check("mv_done", 32'(done), 32'h1);
        tick();

        // add R1,R5
        issue(9'b010_001_101);
        check("add_t1_out", 32'(reg_enable_out), 32'h002);
        check("add_t1_in",  32'(reg_enable_in),  32'h200);
        check("add_t1_done", 32'(done), 32'h0);
        tick();
        check("add_t2_out", 32'(reg_enable_out), 32'h020);
        check("add_t2_in",  32'(reg_enable_in),  32'h100);
        check("add_t2_as",  32'(addsub), 32'h0);
        tick();
        check("add_t3_out", 32'(reg_enable_out), 32'h100);
        check("add_t3_in",  32'(reg_enable_in),  32'h002);
        check("add_t3_done", 32'(done), 32'h1);
        tick();

        // sub R0,R1
        issue(9'b011_000_001);
        check("sub_t1_as", 32'(addsub), 32'h0);
        tick();
        check("sub_t2_as", 32'(addsub), 32'h1);
        check("sub_t2_out", 32'(reg_enable_out), 32'h002);
        tick();
        check("sub_t3_as", 32'(addsub), 32'h0);
        check("sub_t3_in", 32'(reg_enable_in), 32'h001);
        tick();

        // illegal opcode with run held; instr changes while busy
        run = 1'b1;
        instr = 9'b110_000_000;
        tick();
        check("ill_flag", 32'(illegal), 32'h1);
        check("ill_done", 32'(done), 32'h1);
        check("ill_en",   32'({reg_enable_out, reg_enable_in}), 32'h0);
        instr = 9'b001_010_000;
        tick();
        check("ill_gap", 32'(busy), 32'h0);
        tick();
        check("next_in", 32'(reg_enable_in), 32'h004);
        check("next_ill", 32'(illegal), 32'h0);
        run = 1'b0;
        tick();

        // Rx = Ry cases
        issue(9'b000_011_011);
        check("mv33", 32'({reg_enable_out, reg_enable_in}), 32'({10'h008, 10'h008}));
        tick();
        issue(9'b010_010_010);
        tick();
        check("add22_t2", 32'(reg_enable_out), 32'h004);
        tick();
        tick();

        // reset during T2 of add, then mvi R0
        issue(9'b010_001_101);
        tick();
        rst = 1'b0;
        #1;
        check("arst_out",  32'(reg_enable_out), 32'h0);
        check("arst_in",   32'(reg_enable_in),  32'h0);
        check("arst_as",   32'(addsub), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_rst_idle", 32'(busy), 32'h0);
        issue(9'b001_000_000);
        check("post_rst_in",  32'(reg_enable_in), 32'h001);
        check("post_rst_out", 32'(reg_enable_out), 32'h200);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/my_control_unit.md
# my_control_unit

Instruction sequencer for `my_datapath`. It latches a 9-bit instruction when `run` is asserted and decodes it into per-cycle register in/out enables and the ALU add/sub select, which drive the datapath bus. It supports four instructions: mv, mvi, add and sub. Each instruction executes in 1–3 cycles after the fetch cycle, and the last cycle signals `done`.

## Interface
Parameters:
- none (widths fixed by `my_datapath`: 8 GP registers, G, A, external data)

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `run`  in  1  start request; sampled only in IDLE
- `instr`  in  9  instruction word: [8:6] opcode III, [5:3] Rx, [2:0] Ry
- `reg_enable_out`  out  10  bus drivers: [7:0] R0–R7, [8] G, [9] external `data`
- `reg_enable_in`  out  10  register loads: [7:0] R0–R7, [8] G, [9] A
- `addsub`  out  1  ALU select: 0 = A+bus, 1 = A−bus
- `done`  out  1  high during final execute cycle of an instruction
- `busy`  out  1  high whenever state ≠ IDLE
- `illegal`  out  1  high during T1 of an undefined opcode

## Operation
- Internal registers: 2-bit state {IDLE, T1, T2, T3} and a 9-bit IR. No other storage.
- IDLE: all enables 0, `done`=0. If `run`=1 at the clock edge, then IR←`instr` and state→T1. Otherwise stay in IDLE.
- Opcodes and execute cycles:
  - 000 mv Rx,Ry
    - T1: out[Ry], in[Rx], `done` → IDLE
  - 001 mvi Rx,#D
    - T1: out[9] (external data), in[Rx], `done` → IDLE
  - 010 add Rx,Ry
    - T1: out[Rx], in[9] (A) → T2
    - T2: out[Ry], in[8] (G), `addsub`=0 → T3
    - T3: out[8] (G), in[Rx], `done` → IDLE
  - 011 sub Rx,Ry: same as add, but `addsub`=1 in T2
  - 100–111 undefined: T1 asserts no enables, `done`=1, `illegal`=1 → IDLE
- Outputs are decoded combinationally from the registered state and IR only, never from `run` or `instr` directly. They are glitch-free relative to the clock edge.
- Invariant: at most one `reg_enable_out` bit and at most one `reg_enable_in` bit are high in any cycle.
- `addsub` is 0 in every cycle other than T2 of sub.
- Rx = Ry is legal:
  - mv R3,R3 reads and writes R3 in the same cycle.
  - add R2,R2 doubles R2.
- `run` while `busy` is ignored. IR does not change until the next IDLE sample.
- The ALU is combinational from A and bus. G captures the sum or difference at the end of T2.

## Timing
- Reset: asserting `rst`=0 forces state=IDLE and IR=0 immediately, without waiting for a clock edge. All enable bits, `addsub`, `done`, `busy` and `illegal` go to 0 in the same instant.
- Reset mid-instruction aborts the instruction. The destination register is left as already written; a partial add leaves A and/or G modified.
- Latency from the `run` sample edge to the end of the `done` cycle: mv/mvi/illegal 1 cycle, add/sub 3 cycles.
- Back-to-back execution: with `run` held high, every instruction is followed by exactly one IDLE cycle. A new IR is latched on the edge that leaves IDLE.
- Throughput: mv/mvi 2 cycles per instruction, add/sub 4 cycles per instruction.
- `done` is a single-cycle pulse per instruction, coincident with the destination load.
- `busy` is high from the cycle after the `run` sample through the `done` cycle inclusive.
- Release of `rst` (0→1) is synchronized by the environment. The first `run` is sampled on the first rising edge with `rst`=1.

## Test plan
- Reset: drive `rst`=0 mid-T2 of add → all outputs 0 immediately, state IDLE. After release, `run` with mvi R0 executes normally.
- mvi R5,#0x00A3 (instr=9'b001_101_000, data=16'h00A3) → T1: out=10'b10_0000_0000, in=10'b00_0010_0000, `done`=1. R5 reads 0x00A3.
- mv R1,R5 after the above → T1: out bit5, in bit1, `done`. R1=0x00A3, one-cycle latency.
- add R1,R5 with R1=0x00A3, R5=0x00A3 → T1 in bit9, T2 in bit8 with `addsub`=0, T3 out bit8/in bit1. R1=0x0146 and `done` on the third cycle.
- sub R0,R1 with R0=0x0005, R1=0x0007 → `addsub`=1 only in T2. R0=16'hFFFE (wrap-around), `done` after 3 cycles.
- Opcode 110 with `run` held high, then `instr` changed during `busy` → `illegal`=`done`=1 in T1, no enables. The mid-instruction `instr` change is ignored, and the next IR is latched after one IDLE cycle.
